// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared encodings for the load/store unit: access sizes, FSM states and the
// lane-shift helper used by both the extraction and the merge paths.
// No ports.
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_ILLEGAL = 2'b10,
        SIZE_WORD    = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    // Bit position of the addressed byte/half lane inside the 32-bit word.
    // Big-endian puts byte offset 0 in bits [31:24] and half offset 0 in
    // bits [31:16]; little-endian puts offset 0 in the low bits.
    function automatic logic [4:0] lane_shift(input logic [1:0] byte_off,
                                              input logic [1:0] size,
                                              input logic       big_endian);
        logic [1:0] lane;
        lane = 2'b00;
        if (size == SIZE_WORD) begin
            lane = 2'b00;
        end else if (big_endian) begin
            lane = (size == SIZE_BYTE) ? (2'd3 - byte_off) : (2'd2 - byte_off);
        end else begin
            lane = byte_off;
        end
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Groups the pipeline request/response signals and the data-memory port of the
// load/store unit.
//   master : pipeline + memory side (drives requests and mem_readdata_in)
//   slave  : the load/store unit itself
// -----------------------------------------------------------------------------
interface load_store_unit_if;

    logic [31:0] addr_in;
    logic [31:0] writedata_in;
    logic        load_in;
    logic        store_in;
    logic [1:0]  size_in;
    logic        sign_ext_in;
    logic [31:0] readdata_out;
    logic        stall_out;
    logic        error_out;

    logic [31:0] mem_addr_out;
    logic [31:0] mem_writedata_out;
    logic        mem_re_out;
    logic        mem_we_out;
    logic [1:0]  mem_size_out;
    logic [31:0] mem_readdata_in;

    modport master (
        output addr_in, writedata_in, load_in, store_in, size_in, sign_ext_in,
               mem_readdata_in,
        input  readdata_out, stall_out, error_out,
               mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out, mem_size_out
    );

    modport slave (
        input  addr_in, writedata_in, load_in, store_in, size_in, sign_ext_in,
               mem_readdata_in,
        output readdata_out, stall_out, error_out,
               mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out, mem_size_out
    );

endinterface

// File: rtl/lsu_lane_extract.sv
// -----------------------------------------------------------------------------
// lsu_lane_extract
// Purely combinational: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it. Word accesses pass through unchanged.
//   word_i      : full word read from data memory
//   byte_off_i  : byte address bits [1:0]
//   size_i      : access size encoding
//   sign_ext_i  : 1 = sign-extend, 0 = zero-extend
//   data_o      : extracted, extended result
// -----------------------------------------------------------------------------
module lsu_lane_extract
    import load_store_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);

    logic [4:0]  shift;
    logic [31:0] shifted;

    always_comb begin
        shift   = lane_shift(byte_off_i, size_i, BIG_ENDIAN);
        shifted = word_i >> shift;
        data_o  = shifted;
        case (size_i)
            SIZE_BYTE: data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            default:   data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Sits between the pipeline and a word-wide, asynchronous-read data memory.
// Loads complete in the same cycle; word stores write directly; byte/half
// stores do a read (one stall cycle) followed by a merged full-word write.
//   clock : single clock, rising edge
//   reset : asynchronous, active low
//   bus   : pipeline request/response and data-memory port (slave side)
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | accept requests; loads/word stores finish here
//   ST_MERGE | write merge register with the new byte/half lanes inserted
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] merge_q, merge_d;

    logic        any_req;
    logic        misaligned;
    logic        size_illegal;
    logic        req_err;
    logic        legal_load;
    logic        legal_store;
    logic        sub_word;
    logic [4:0]  shift;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged_word;
    logic [31:0] extracted;

    // ---------------- request decode ----------------
    always_comb begin
        any_req      = bus.load_in | bus.store_in;
        size_illegal = (bus.size_in == SIZE_ILLEGAL);
        misaligned   = ((bus.size_in == SIZE_HALF) & bus.addr_in[0]) |
                       ((bus.size_in == SIZE_WORD) & (bus.addr_in[1:0] != 2'b00));
        req_err      = any_req & (size_illegal | misaligned | (bus.load_in & bus.store_in));
        legal_load   = bus.load_in  & ~req_err;
        legal_store  = bus.store_in & ~req_err;
        sub_word     = (bus.size_in != SIZE_WORD);
    end

    // ---------------- load lane extraction ----------------
    lsu_lane_extract #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_extract (
        .word_i     (bus.mem_readdata_in),
        .byte_off_i (bus.addr_in[1:0]),
        .size_i     (bus.size_in),
        .sign_ext_i (bus.sign_ext_in),
        .data_o     (extracted)
    );

    // ---------------- store merge ----------------
    // Inputs are held stable through the stall, so the live address/data
    // select the lanes during MERGE.
    always_comb begin
        shift       = lane_shift(bus.addr_in[1:0], bus.size_in, BIG_ENDIAN);
        lane_mask   = ((bus.size_in == SIZE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
        lane_data   = ((bus.size_in == SIZE_BYTE) ? {24'd0, bus.writedata_in[7:0]}
                                                  : {16'd0, bus.writedata_in[15:0]}) << shift;
        merged_word = (merge_q & ~lane_mask) | lane_data;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        merge_d = merge_q;
        case (state_q)
            ST_IDLE: begin
                if (legal_store && sub_word) begin
                    state_d = ST_MERGE;
                    merge_d = bus.mem_readdata_in;
                end
            end
            ST_MERGE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Everything is gated by reset so an aborted MERGE can never leak a write
    // and stray requests during reset report nothing.
    always_comb begin
        bus.readdata_out      = 32'd0;
        bus.stall_out         = 1'b0;
        bus.error_out         = 1'b0;
        bus.mem_re_out        = 1'b0;
        bus.mem_we_out        = 1'b0;
        bus.mem_writedata_out = 32'd0;
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    bus.error_out = req_err;
                    if (legal_load) begin
                        bus.mem_re_out   = 1'b1;
                        bus.readdata_out = extracted;
                    end else if (legal_store) begin
                        if (sub_word) begin
                            bus.mem_re_out = 1'b1;
                            bus.stall_out  = 1'b1;
                        end else begin
                            bus.mem_we_out        = 1'b1;
                            bus.mem_writedata_out = bus.writedata_in;
                        end
                    end
                end
                ST_MERGE: begin
                    bus.mem_we_out        = 1'b1;
                    bus.mem_writedata_out = merged_word;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr_out = {bus.addr_in[31:2], 2'b00};
    assign bus.mem_size_out = SIZE_WORD;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed checks of a big-endian and a little-endian load_store_unit driven
// with identical stimulus.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    load_store_unit_if bus_be();
    load_store_unit_if bus_le();

    assign bus_le.addr_in         = bus_be.addr_in;
    assign bus_le.writedata_in    = bus_be.writedata_in;
    assign bus_le.load_in         = bus_be.load_in;
    assign bus_le.store_in        = bus_be.store_in;
    assign bus_le.size_in         = bus_be.size_in;
    assign bus_le.sign_ext_in     = bus_be.sign_ext_in;
    assign bus_le.mem_readdata_in = bus_be.mem_readdata_in;

    load_store_unit #(.BIG_ENDIAN(1'b1)) dut_be (
        .clock (clock),
        .reset (reset),
        .bus   (bus_be.slave)
    );

    load_store_unit #(.BIG_ENDIAN(1'b0)) dut_le (
        .clock (clock),
        .reset (reset),
        .bus   (bus_le.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // {error, re, we, stall}
    logic [31:0] flags_be, flags_le;
    assign flags_be = {28'd0, bus_be.error_out, bus_be.mem_re_out, bus_be.mem_we_out, bus_be.stall_out};
    assign flags_le = {28'd0, bus_le.error_out, bus_le.mem_re_out, bus_le.mem_we_out, bus_le.stall_out};

    localparam logic [31:0] F_NONE  = 32'h0;
    localparam logic [31:0] F_ERR   = 32'h8;
    localparam logic [31:0] F_RE    = 32'h4;
    localparam logic [31:0] F_WE    = 32'h2;
    localparam logic [31:0] F_STALL = 32'h5;   // re + stall

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic st, input logic [1:0] sz,
                         input logic sx, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] mem);
        bus_be.load_in         = ld;
        bus_be.store_in        = st;
        bus_be.size_in         = sz;
        bus_be.sign_ext_in     = sx;
        bus_be.addr_in         = addr;
        bus_be.writedata_in    = wd;
        bus_be.mem_readdata_in = mem;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset active with a bad request pending: nothing may be reported.
        drive(1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h1000_0003, 32'h0, 32'h1234_5678);
        #1;
        check("rst_flags", flags_be, F_NONE);
        check("rst_rdata", bus_be.readdata_out, 32'h0);

        @(negedge clock);
        reset = 1'b1;
        idle();
        #1;
        check("idle_flags", flags_be, F_NONE);
        check("idle_rdata", bus_be.readdata_out, 32'h0);
        check("mem_size", {30'd0, bus_be.mem_size_out}, 32'h3);

        // Word load
        @(negedge clock);
        drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF);
        #1;
        check("wload_rdata", bus_be.readdata_out, 32'hDEAD_BEEF);
        check("wload_flags", flags_be, F_RE);
        check("wload_addr", bus_be.mem_addr_out, 32'h1000_0004);

        // Byte loads
        @(negedge clock);
        drive(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h1000_0001, 32'h0, 32'h12F4_5678);
        #1;
        check("bload_sx_be", bus_be.readdata_out, 32'hFFFF_FFF4);
        check("bload_sx_le", bus_le.readdata_out, 32'h0000_0056);
        check("bload_addr", bus_be.mem_addr_out, 32'h1000_0000);
        bus_be.sign_ext_in = 1'b0;
        #1;
        check("bload_zx_be", bus_be.readdata_out, 32'h0000_00F4);
        check("bload_zx_le", bus_le.readdata_out, 32'h0000_0056);

        @(negedge clock);
        drive(1'b1, 1'b0, SIZE_BYTE, 1'b1, 32'h1000_0003, 32'h0, 32'h12F4_5678);
        #1;
        check("bload3_be", bus_be.readdata_out, 32'h0000_0078);
        check("bload3_le", bus_le.readdata_out, 32'h0000_0012);

        // Half loads
        @(negedge clock);
        drive(1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h1000_0000, 32'h0, 32'h8001_7FFF);
        #1;
        check("hload0_be", bus_be.readdata_out, 32'hFFFF_8001);
        check("hload0_le", bus_le.readdata_out, 32'h0000_7FFF);
        bus_be.addr_in = 32'h1000_0002;
        #1;
        check("hload2_be", bus_be.readdata_out, 32'h0000_7FFF);
        check("hload2_le", bus_le.readdata_out, 32'hFFFF_8001);

        // Error cases
        @(negedge clock);
        drive(1'b1, 1'b0, SIZE_HALF, 1'b1, 32'h1000_0003, 32'h0, 32'h1234_5678);
        #1;
        check("err_half_flags", flags_be, F_ERR);
        check("err_half_rdata", bus_be.readdata_out, 32'h0);
        drive(1'b1, 1'b0, SIZE_ILLEGAL, 1'b0, 32'h1000_0000, 32'h0, 32'h1234_5678);
        #1;
        check("err_size_flags", flags_be, F_ERR);
        drive(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h1000_0002, 32'h1111_1111, 32'h1234_5678);
        #1;
        check("err_wst_flags", flags_be, F_ERR);
        drive(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h7FFF_F000, 32'h1111_1111, 32'h1234_5678);
        #1;
        check("err_ldst_flags", flags_be, F_ERR);
        @(negedge clock);
        check("err_no_merge", flags_be, F_ERR);

        // Word store
        @(negedge clock);
        drive(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'h1000_0008, 32'hCAFE_F00D, 32'h1234_5678);
        #1;
        check("wst_flags", flags_be, F_WE);
        check("wst_wdata", bus_be.mem_writedata_out, 32'hCAFE_F00D);
        check("wst_addr", bus_be.mem_addr_out, 32'h1000_0008);

        // Half store read-merge-write; memory word changes during MERGE to
        // prove the merge register holds the first-cycle read.
        @(negedge clock);
        drive(1'b0, 1'b1, SIZE_HALF, 1'b0, 32'h1000_0002, 32'h0000_ABCD, 32'h1122_3344);
        #1;
        check("hst_c1_flags", flags_be, F_STALL);
        @(negedge clock);
        bus_be.mem_readdata_in = 32'h5555_5555;
        #1;
        check("hst_c2_flags", flags_be, F_WE);
        check("hst_c2_be", bus_be.mem_writedata_out, 32'h1122_ABCD);
        check("hst_c2_le", bus_le.mem_writedata_out, 32'hABCD_3344);
        check("hst_c2_addr", bus_be.mem_addr_out, 32'h1000_0000);
        @(negedge clock);
        idle();
        #1;
        check("hst_done_flags", flags_be, F_NONE);

        // Byte store into the serial region still merges
        @(negedge clock);
        drive(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'hFFFF_0003, 32'h1234_56A5, 32'hAABB_CCDD);
        #1;
        check("bst_c1_flags", flags_be, F_STALL);
        @(negedge clock);
        #1;
        check("bst_c2_flags", flags_be, F_WE);
        check("bst_c2_be", bus_be.mem_writedata_out, 32'hAABB_CCA5);
        check("bst_c2_le", bus_le.mem_writedata_out, 32'hA5BB_CCDD);
        check("bst_c2_addr", bus_be.mem_addr_out, 32'hFFFF_0000);
        @(negedge clock);
        idle();

        // Reset while in MERGE aborts the write
        @(negedge clock);
        drive(1'b0, 1'b1, SIZE_BYTE, 1'b0, 32'h1000_0001, 32'h0000_0077, 32'h1122_3344);
        #1;
        check("rm_c1_flags", flags_be, F_STALL);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rm_abort_flags", flags_be, F_NONE);
        check("rm_abort_wdata", bus_be.mem_writedata_out, 32'h0);
        check("rm_abort_rdata", bus_be.readdata_out, 32'h0);
        @(negedge clock);
        check("rm_hold_flags", flags_be, F_NONE);
        reset = 1'b1;
        #1;
        // Back in IDLE: the still-pending store restarts with its read/stall.
        check("rm_idle_flags", flags_be, F_STALL);
        @(negedge clock);
        #1;
        check("rm_restart_be", bus_be.mem_writedata_out, 32'h1177_3344);
        @(negedge clock);
        idle();
        #1;
        check("end_flags", flags_be, F_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
